// File: rtl/ram_pair_reader.sv
// Read-side controller for a 1W/2R block RAM: issues paired reads in lockstep and streams the
// (port0, port1) word pairs through a 2-entry skid FIFO that absorbs the RAM's read latency.
module ram_pair_reader #(
    parameter int unsigned DataWidth = 1024,
    parameter int unsigned Depth     = 256,
    localparam int unsigned Aw       = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [Aw-1:0]        base0_i,
    input  logic [Aw-1:0]        base1_i,
    input  logic [Aw:0]          count_i,
    output logic [Aw-1:0]        read_addr0_o,
    output logic [Aw-1:0]        read_addr1_o,
    input  logic [DataWidth-1:0] dout0_i,
    input  logic [DataWidth-1:0] dout1_i,
    output logic [DataWidth-1:0] m_data0_o,
    output logic [DataWidth-1:0] m_data1_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    localparam logic [Aw-1:0] AddrMax = Aw'(Depth - 1);
    localparam logic [Aw:0]   CntOne  = (Aw + 1)'(1);

    state_e              state_q, state_d;
    logic [Aw-1:0]       addr0_q, addr0_d, addr1_q, addr1_d;
    logic [Aw:0]         issued_q, issued_d, accepted_q, accepted_d, count_q, count_d;
    logic                inflight_q;
    logic                issue, push, pop;
    logic [2:0]          level;

    logic [2*DataWidth-1:0] mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             occ_q, occ_d;

    assign push = inflight_q;
    assign pop  = m_valid_o & m_ready_i;

    // Entries already held or on their way; one slot must stay free for the read being issued.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q};

    always_comb begin
        state_d    = state_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        issued_d   = issued_q;
        accepted_d = pop ? accepted_q + CntOne : accepted_q;
        count_d    = count_q;
        issue      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    count_d = count_i;
                    if (count_i != '0) begin
                        addr0_d    = base0_i;
                        addr1_d    = base1_i;
                        issued_d   = '0;
                        accepted_d = '0;
                        state_d    = StRun;
                    end else begin
                        state_d = StFin;
                    end
                end
            end
            StRun: begin
                issue = level < (3'd2 + {2'b00, pop});
                if (issue) begin
                    addr0_d  = (addr0_q == AddrMax) ? '0 : addr0_q + Aw'(1);
                    addr1_d  = (addr1_q == AddrMax) ? '0 : addr1_q + Aw'(1);
                    issued_d = issued_q + CntOne;
                    if (issued_d == count_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && m_last_o) state_d = StFin;
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr0_q    <= '0;
            addr1_q    <= '0;
            issued_q   <= '0;
            accepted_q <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            count_q    <= count_d;
            inflight_q <= issue;
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop) occ_d = occ_q + 2'd1;
        else if (!push && pop) occ_d = occ_q - 2'd1;
    end

    // The RAM has no read enable, so the word arriving after an issue is always captured.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {dout1_i, dout0_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            occ_q <= occ_d;
        end
    end

    assign read_addr0_o = addr0_q;
    assign read_addr1_o = addr1_q;
    assign m_data0_o    = mem_q[rd_ptr_q][DataWidth-1:0];
    assign m_data1_o    = mem_q[rd_ptr_q][2*DataWidth-1:DataWidth];
    assign m_valid_o    = occ_q != '0;
    assign m_last_o     = m_valid_o && ((accepted_q + CntOne) == count_q);
    assign busy_o       = state_q != StIdle;
    assign done_o       = state_q == StFin;

endmodule

// File: tb/tb_ram_pair_reader.sv
// Directed bench for ram_pair_reader: a behavioural 1W/2R RAM holding mem[i]=i feeds the DUT.
module tb_ram_pair_reader;

    localparam int unsigned Dw = 16;
    localparam int unsigned Dp = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    base0, base1;
    logic [8:0]    count;
    logic [7:0]    read_addr0, read_addr1;
    logic [Dw-1:0] dout0, dout1;
    logic [Dw-1:0] m_data0, m_data1;
    logic          m_valid, m_ready, m_last, busy, done;

    logic [Dw-1:0] ram [Dp];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        dout0 <= ram[read_addr0];
        dout1 <= ram[read_addr1];
    end

    ram_pair_reader #(
        .DataWidth (Dw),
        .Depth     (Dp)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base0_i      (base0),
        .base1_i      (base1),
        .count_i      (count),
        .read_addr0_o (read_addr0),
        .read_addr1_o (read_addr1),
        .dout0_i      (dout0),
        .dout1_i      (dout1),
        .m_data0_o    (m_data0),
        .m_data1_o    (m_data1),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_last_o     (m_last),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ":addr0"}, 32'(read_addr0), 0);
        check_val({tag, ":addr1"}, 32'(read_addr1), 0);
        check_val({tag, ":data0"}, 32'(m_data0), 0);
        check_val({tag, ":data1"}, 32'(m_data1), 0);
        check_val({tag, ":valid"}, 32'(m_valid), 0);
        check_val({tag, ":last"}, 32'(m_last), 0);
        check_val({tag, ":busy"}, 32'(busy), 0);
        check_val({tag, ":done"}, 32'(done), 0);
    endtask

    // mode 0: ready held high; 1: random ready with a 5-cycle hold low; 2: ready high while
    // start is re-asserted with different operands during the command.
    task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1, input int cnt,
                          input int mode, input string name);
        int          beats, first_v, done_c, busy_c;
        logic        stall, done_seen;
        logic [15:0] h0, h1;
        logic        hl;
        logic [7:0]  e0, e1;
        beats = 0; first_v = 0; done_c = 0; busy_c = 0;
        stall = 1'b0; done_seen = 1'b0; h0 = '0; h1 = '0; hl = 1'b0;
        @(negedge clk);
        start = 1'b1; base0 = b0; base1 = b1; count = 9'(cnt); m_ready = 1'b1;
        for (int c = 1; c <= 300 && !done_seen; c++) begin
            @(negedge clk);
            start = (mode == 2) && (c <= 2);
            if (mode == 2) begin
                base0 = 8'd99; base1 = 8'd77; count = 9'd3;
            end
            if (mode == 1) m_ready = (c >= 6 && c <= 10) ? 1'b0 : 1'($urandom_range(0, 1));
            else m_ready = 1'b1;
            if (busy) busy_c++;
            if (stall) begin
                check_val({name, ":hold_valid"}, 32'(m_valid), 1);
                check_val({name, ":hold_d0"}, 32'(m_data0), 32'(h0));
                check_val({name, ":hold_d1"}, 32'(m_data1), 32'(h1));
                check_val({name, ":hold_last"}, 32'(m_last), 32'(hl));
            end
            if (m_valid && first_v == 0) first_v = c;
            if (m_valid && m_ready) begin
                e0 = b0 + 8'(beats);
                e1 = b1 + 8'(beats);
                check_val({name, ":d0"}, 32'(m_data0), 32'(e0));
                check_val({name, ":d1"}, 32'(m_data1), 32'(e1));
                check_val({name, ":last"}, 32'(m_last), 32'(beats == cnt - 1));
                beats++;
            end
            stall = m_valid && !m_ready;
            h0 = m_data0; h1 = m_data1; hl = m_last;
            if (done) begin
                done_seen = 1'b1;
                done_c    = c;
            end
        end
        check_val({name, ":done_seen"}, 32'(done_seen), 1);
        check_val({name, ":beats"}, 32'(beats), 32'(cnt));
        if (mode != 1) begin
            check_val({name, ":first_valid"}, 32'(first_v), (cnt == 0) ? 0 : 3);
            check_val({name, ":done_cycle"}, 32'(done_c), (cnt == 0) ? 1 : 32'(cnt + 3));
            check_val({name, ":busy_cycles"}, 32'(busy_c), (cnt == 0) ? 1 : 32'(cnt + 3));
        end
        start = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check_val({name, ":done_pulse_end"}, 32'(done), 0);
        check_val({name, ":busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        int beats;
        for (int i = 0; i < Dp; i++) ram[i] = 16'(i);
        rst_n = 1'b0; start = 1'b0; base0 = '0; base1 = '0; count = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        do_cmd(8'd0, 8'd128, 4, 0, "basic");
        do_cmd(8'd254, 8'd0, 4, 0, "wrap");
        check_val("wrap:addr0_end", 32'(read_addr0), 2);
        check_val("wrap:addr1_end", 32'(read_addr1), 4);
        do_cmd(8'd50, 8'd60, 0, 0, "zero");
        check_val("zero:addr0_kept", 32'(read_addr0), 2);
        check_val("zero:addr1_kept", 32'(read_addr1), 4);
        do_cmd(8'd30, 8'd200, 8, 1, "bp");
        do_cmd(8'd5, 8'd40, 3, 2, "restart");

        // Mid-command reset one cycle after beat 2 is accepted.
        @(negedge clk);
        start = 1'b1; base0 = 8'd0; base1 = 8'd128; count = 9'd16; m_ready = 1'b1;
        beats = 0;
        for (int c = 1; c <= 20 && beats < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_valid && m_ready) beats++;
        end
        check_val("midrst:beats_before", 32'(beats), 3);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        do_cmd(8'd10, 8'd20, 2, 0, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_pair_reader.md
# ram_pair_reader

Read-side controller for the 1-write/2-read block RAM used by the Multi-MAC matrix multiplier. A single start command supplies two base addresses and a beat count. The block then drives both RAM read ports in lockstep and absorbs the RAM's one-cycle registered-read latency. It delivers each (port0, port1) word pair as one beat on a valid/ready stream with backpressure, `last` and a `done` pulse.

## Interface
- `DATA_WIDTH`, 1024: width of each RAM word and each output data lane.
- `DEPTH`, 256: RAM depth. `AW = $clog2(DEPTH)` is the address width.
- `clk` in 1: rising-edge clock, shared with the RAM.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: command strobe; sampled only in IDLE.
- `base0` in AW: first read address for port 0.
- `base1` in AW: first read address for port 1.
- `count` in AW+1: beats to read, 0..DEPTH.
- `read_addr0` out AW: to RAM `read_addr0`; registered.
- `read_addr1` out AW: to RAM `read_addr1`; registered.
- `dout0` in DATA_WIDTH: from RAM port 0; valid the cycle after its address is registered.
- `dout1` in DATA_WIDTH: from RAM port 1; same timing as `dout0`.
- `m_data0` out DATA_WIDTH: beat data, port-0 word.
- `m_data1` out DATA_WIDTH: beat data, port-1 word.
- `m_valid` out 1: beat available.
- `m_ready` in 1: consumer accepts the beat.
- `m_last` out 1: marks the final beat of the command.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the command completes.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for the buffer to empty.
  - FIN: asserts `done` for one cycle, then returns to IDLE.
- IDLE & `start`:
  - `count`≠0: load `read_addr0`=`base0`, `read_addr1`=`base1`, issued=0, accepted=0; go to RUN.
  - `count`=0: go directly to FIN; no beats, no reads.
- RUN issue rule: issue when `occ + inflight - pop < 2`.
  - `occ` is output-buffer occupancy (0..2).
  - `inflight` is 1 if the previous cycle issued.
  - `pop` = `m_valid & m_ready`.
- On issue: the current registered addresses are the read. At the next edge, both addresses increment by 1 modulo DEPTH (DEPTH-1 wraps to 0), issued increments, and `inflight` is set.
- When issued reaches `count`, go to DRAIN. Addresses then hold their last value; they are don't-care.
- Capture: in the cycle after an issue, `{dout1,dout0}` is written into the 2-entry FIFO at the next edge, unconditionally. The issue rule guarantees space.
  - The RAM has no read enable, so data is never re-read.
  - Skipping a capture is a bug.
- Output: the FIFO head drives `m_data0/1`. `m_valid` = (`occ`≠0).
- `m_last` = head is beat number `count`-1.
- While `m_valid` & !`m_ready`: `m_data0/1` and `m_last` stay stable.
- DRAIN → FIN when the final beat is accepted. FIN → IDLE after one cycle.
- `start` outside IDLE is ignored.
- Reset, including mid-command: state IDLE, FIFO flushed, `inflight`=0, counters 0. Beats in flight are discarded.

## Timing
- Reset values: `read_addr0/1`=0, `m_data0/1`=0, `m_valid`=0, `m_last`=0, `busy`=0, `done`=0.
- Start accepted at edge E0 → addresses valid after E0 → RAM data after E1 → FIFO write at E2. First `m_valid` is high in the cycle after E2: 3 cycles after the start edge.
- Throughput with `m_ready` held high: 1 beat/cycle sustained.
- `count`=N with no stalls: last beat in cycle N+2 after E0, `done` in cycle N+3.
- `count`=0: `busy` high for 1 cycle (FIN), with `done` in that same cycle.
- Simultaneous FIFO push and pop: `occ` is unchanged, and order is preserved.
- `done` is asserted only in FIN; `busy` is high during FIN.

## Test plan
- Basic: RAM preloaded with mem[i]=i. start base0=0, base1=128, count=4, `m_ready`=1 → beats (0,128),(1,129),(2,130),(3,131). `m_last` on beat 3. First valid 3 cycles after start. `done` 1 cycle after the last beat.
- Wrap: base0=254, base1=0, count=4 → port0 reads 254,255,0,1; port1 reads 0,1,2,3.
- Backpressure: count=8, `m_ready` toggled by random pattern plus a 5-cycle hold low → all 8 beats delivered in order, no loss or duplication. Data stable while stalled. `occ` never exceeds 2.
- count=0 → no `m_valid`. `busy` and `done` both high for exactly one cycle. Addresses unchanged.
- Mid-op reset: `rst_n` low 1 cycle after beat 2 of count=16 → all outputs return to reset values. A new start base0=10, count=2 yields only (10, base1) and (11, base1+1).
- `start` re-asserted during RUN with different bases → ignored. The original command completes unchanged.
